// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode 0 slave (sample MOSI on SCLK rise, shift MISO on SCLK fall, MSB
// first). All SPI pins are asynchronous to clk. They are synchronized and
// edge-detected, so the design runs entirely in the clk domain. clk must run
// at least 8x faster than sclk.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   sclk_in    SPI serial clock from the master (asynchronous)
//   cs_n_in    SPI chip select from the master, active-low (asynchronous)
//   mosi_in    SPI serial data from the master (asynchronous)
//   miso_out   SPI serial data to the master (0 while not selected)
//   tx_data    word to return to the master
//   tx_load    writes tx_data into the transmit buffer while tx_ready is high
//   tx_ready   transmit buffer empty
//   rx_data    last completely received word, held until the next one
//   rx_valid   one-clk pulse: rx_data has just been updated
//   frame_err  one-clk pulse: chip select rose in the middle of a word
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  output logic             miso_out,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Synchronizers. sclk has a third stage and cs_n has a history flop so that
  // edges are detected on fully synchronized values.
  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_prev;
  logic mosi_s1, mosi_s2;

  // sync_warm fills with ones after reset. Once bit 1 is set, cs_s2 holds a
  // real sample of the pin rather than its reset value. armed is set only
  // after cs_n has really been seen high. This stops a frame that was already
  // in progress when reset was released from being picked up halfway.
  logic [1:0] sync_warm;
  logic       armed;

  logic [CNT_W-1:0] bit_cnt;
  logic             reload_pending;  // a word completed; next sclk fall reloads
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic start_frame, end_frame, rise_act, fall_act, load_shift;
  logic [WIDTH-1:0] rx_next;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_prev;
  assign cs_rise   = cs_s2 & ~cs_prev;
  assign rx_next   = {rx_shift[WIDTH-2:0], mosi_s2};

  // ---------------------------------------------------------------------------
  // Next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    rise_act    = 1'b0;
    fall_act    = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && cs_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect takes priority over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else begin
          rise_act = sclk_rise;
          fall_act = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffer moves into the shift register at frame start and on the first
  // sclk fall after each completed word.
  assign load_shift = start_frame | (fall_act & reload_pending);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers (buffer, shift and receive words) are reset
      // here as well as the control state. This makes every output well
      // defined right after reset, not only the handshake flags.
      state_q        <= IDLE;
      sclk_s1        <= 1'b0;
      sclk_s2        <= 1'b0;
      sclk_s3        <= 1'b0;
      cs_s1          <= 1'b1;
      cs_s2          <= 1'b1;
      cs_prev        <= 1'b1;
      mosi_s1        <= 1'b0;
      mosi_s2        <= 1'b0;
      sync_warm      <= 2'b00;
      armed          <= 1'b0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      tx_shift       <= '0;
      rx_shift       <= '0;
      tx_buf         <= '0;
      tx_full        <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples the
      // pre-edge value of its neighbours. This is what turns each chain below
      // into a real shift pipeline.
      sclk_s1   <= sclk_in;
      sclk_s2   <= sclk_s1;
      sclk_s3   <= sclk_s2;
      cs_s1     <= cs_n_in;
      cs_s2     <= cs_s1;
      cs_prev   <= cs_s2;
      mosi_s1   <= mosi_in;
      mosi_s2   <= mosi_s1;
      sync_warm <= {sync_warm[0], 1'b1};
      if (sync_warm[1] && cs_s2) armed <= 1'b1;

      state_q   <= state_d;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Transmit path. The buffer empties on a transfer. The load check below
      // uses the pre-transfer tx_full, so a same-cycle load is accepted only
      // if the buffer was already empty. In that case the transfer carries
      // all-ones and the new word waits in the buffer for the next word.
      if (load_shift) begin
        tx_shift <= tx_full ? tx_buf : '1;
        tx_full  <= 1'b0;
      end else if (fall_act) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
      if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      // Receive path
      if (start_frame) begin
        bit_cnt        <= '0;
        rx_shift       <= '0;
        reload_pending <= 1'b0;
      end
      if (end_frame) begin
        frame_err      <= (bit_cnt != '0);
        bit_cnt        <= '0;
        rx_shift       <= '0;
        reload_pending <= 1'b0;
      end
      if (rise_act) begin
        rx_shift <= rx_next;
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          rx_data        <= rx_next;
          rx_valid       <= 1'b1;
          bit_cnt        <= '0;
          reload_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (fall_act && reload_pending) reload_pending <= 1'b0;
    end
  end

  assign tx_ready = ~tx_full;
  assign miso_out = (state_q == ACTIVE) ? tx_shift[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Bench for spi_slave. The stimulus acts as an SPI master. When each word is
// issued, it pushes the expected receive word and the expected MISO word into
// queues. Two independent monitors pop and compare: one on rx_valid in the clk
// domain, one that assembles MISO bits on each sclk rise. The transmit buffer
// is modelled as a one-entry slot. A word loaded while the slot is full is
// dropped. The slot is drained at frame start and after each completed word,
// and a drain of an empty slot yields all-ones.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int W = 8;
  localparam int H = 80;  // sclk half period (clk period is 10)

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk_in;
  logic         cs_n_in;
  logic         mosi_in;
  logic         miso_out;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .cs_n_in   (cs_n_in),
    .mosi_in   (mosi_in),
    .miso_out  (miso_out),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] rx_exp[$];
  logic [W-1:0] miso_exp[$];
  int           exp_err = 0;
  int           err_seen = 0;
  logic [W-1:0] exp_last_rx = '0;

  bit           mdl_full = 1'b0;
  logic [W-1:0] mdl_val = '0;

  bit           miso_mon_en = 1'b1;
  bit           mid_load_en = 1'b0;
  logic [W-1:0] frame_words[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // One-entry buffer model: take the stored word (or all-ones) and empty it.
  function automatic logic [W-1:0] consume();
    logic [W-1:0] v;
    v = mdl_full ? mdl_val : '1;
    mdl_full = 1'b0;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rx_valid) begin
      check("frame_err alongside rx_valid", 32'(frame_err), 32'd0);
      if (rx_exp.size() == 0) begin
        flag("unexpected rx_valid");
      end else begin
        mon_e = rx_exp.pop_front();
        check("rx_data", 32'(rx_data), 32'(mon_e));
      end
    end
    if (frame_err) err_seen++;
  end

  logic [W-1:0] m_word = '0;
  int           m_cnt = 0;
  always @(posedge sclk_in or posedge cs_n_in) begin
    if (cs_n_in) begin
      m_cnt = 0;
    end else if (miso_mon_en) begin
      m_word = {m_word[W-2:0], miso_out};
      m_cnt++;
      if (m_cnt == W) begin
        m_cnt = 0;
        if (miso_exp.size() == 0) flag("unexpected miso word");
        else check("miso word", 32'(m_word), 32'(miso_exp.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic load_word(input logic [W-1:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    if (!mdl_full) begin
      mdl_full = 1'b1;
      mdl_val  = v;
    end
    @(negedge clk);
    tx_load = 1'b0;
    check("tx_ready after load", 32'(tx_ready), 32'(!mdl_full));
  endtask

  // Send nwords words from frame_words. The last word carries last_bits bits,
  // which is fewer than W for an aborted frame.
  task automatic send_frame(input int nwords, input int last_bits);
    logic [W-1:0] cur_miso;
    logic [W-1:0] sh;
    int           nb;
    cs_n_in  = 1'b0;
    cur_miso = consume();
    for (int w = 0; w < nwords; w++) begin
      sh = frame_words[w];
      nb = (w == nwords - 1) ? last_bits : W;
      if (nb == W) begin
        rx_exp.push_back(frame_words[w]);
        miso_exp.push_back(cur_miso);
        exp_last_rx = frame_words[w];
      end
      for (int b = 0; b < nb; b++) begin
        mosi_in = sh[W-1];
        sh      = sh << 1;
        #H;
        sclk_in = 1'b1;
        if (mid_load_en && b == 3) load_word(W'($urandom));
        #H;
        sclk_in = 1'b0;
      end
      if (nb == W) cur_miso = consume();
    end
    if (last_bits != W) exp_err++;
    #H;
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    #(2 * H);
    check("frame_err count", 32'(err_seen), 32'(exp_err));
    check("rx_data held", 32'(rx_data), 32'(exp_last_rx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " miso_out"},  32'(miso_out),  32'd0);
    check({tag, " rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " rx_data"},   32'(rx_data),   32'd0);
    check({tag, " tx_ready"},  32'(tx_ready),  32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    sclk_in = 1'b0;
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Loaded word returned while 0xA5 is received.
    load_word(W'(8'h3C));
    frame_words[0] = W'(8'hA5);
    send_frame(1, W);
    check("tx_ready after drain", 32'(tx_ready), 32'd1);

    // Two back-to-back words with the buffer empty.
    frame_words[0] = W'(8'h01);
    frame_words[1] = W'(8'h80);
    send_frame(2, W);

    // Aborted after five bits.
    frame_words[0] = W'(8'h5A);
    send_frame(1, 5);

    // Second load ignored while the buffer is full.
    load_word(W'(8'h11));
    load_word(W'(8'h22));
    frame_words[0] = W'(8'hC3);
    send_frame(1, W);
    check("tx_ready after frame", 32'(tx_ready), 32'd1);

    // sclk activity while not selected.
    for (int i = 0; i < 2 * W; i++) begin
      mosi_in = 1'($urandom);
      #H;
      sclk_in = 1'b1;
      #H;
      sclk_in = 1'b0;
      check("miso_out deselected", 32'(miso_out), 32'd0);
    end
    check("no frame_err deselected", 32'(err_seen), 32'(exp_err));

    // Reset in the middle of a frame, then sclk pulses with cs_n still low.
    miso_mon_en = 1'b0;
    frame_words[0] = W'($urandom);
    cs_n_in = 1'b0;
    void'(consume());
    for (int b = 0; b < 3; b++) begin
      mosi_in = 1'($urandom);
      #H;
      sclk_in = 1'b1;
      #H;
      sclk_in = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid-frame reset");
    rst         = 1'b0;
    mdl_full    = 1'b0;
    exp_last_rx = '0;
    for (int b = 0; b < W; b++) begin
      mosi_in = 1'($urandom);
      #H;
      sclk_in = 1'b1;
      #H;
      sclk_in = 1'b0;
      check("miso_out after reset", 32'(miso_out), 32'd0);
    end
    #H;
    cs_n_in = 1'b1;
    #(2 * H);
    check("no frame_err after reset", 32'(err_seen), 32'(exp_err));
    check("rx_data after reset", 32'(rx_data), 32'd0);
    miso_mon_en = 1'b1;
    frame_words[0] = W'(8'h96);
    send_frame(1, W);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      int nw, lb;
      nw = int'($urandom_range(1, 3));
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : W;
      for (int w = 0; w < 4; w++) frame_words[w] = W'($urandom);
      if ($urandom_range(0, 1) == 1) load_word(W'($urandom));
      mid_load_en = ($urandom_range(0, 2) == 0);
      send_frame(nw, lb);
    end
    mid_load_en = 1'b0;

    repeat (20) @(negedge clk);
    check("rx words outstanding", 32'(rx_exp.size()), 32'd0);
    check("miso words outstanding", 32'(miso_exp.size()), 32'd0);
    check("frame_err total", 32'(err_seen), 32'(exp_err));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bits per SPI frame word.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: sclk_in  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL have port: cs_n_in  input  1  chip select from master, active-low, asynchronous.
REQ-006 SHALL have port: mosi_in  input  1  serial data from master, asynchronous.
REQ-007 SHALL have port: miso_out  output  1  serial data to master.
REQ-008 SHALL have port: tx_data  input  WIDTH  word to return to master.
REQ-009 SHALL have port: tx_load  input  1  writes tx_data into transmit buffer when tx_ready high.
REQ-010 SHALL have port: tx_ready  output  1  transmit buffer empty.
REQ-011 SHALL have port: rx_data  output  WIDTH  last received word, held until next word.
REQ-012 SHALL have port: rx_valid  output  1  one-clk pulse, rx_data updated.
REQ-013 SHALL have port: frame_err  output  1  one-clk pulse, frame aborted mid-word.

Function
REQ-014 SHALL pass sclk_in, cs_n_in, mosi_in through two-flop synchronizers; sclk SHALL have a third stage for edge detection (rise = s2 & ~s3, fall = ~s2 & s3).
REQ-015 SHALL support SPI mode 0 only: sample MOSI on sclk rise, shift MISO on sclk fall, MSB first.
REQ-016 SHALL require clk frequency >= 8x sclk frequency; behaviour outside this is unspecified.
REQ-017 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE only on synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n rising edge.
REQ-018 SHALL, on IDLE->ACTIVE, clear bit counter and load shift register from transmit buffer (buffer then empty, tx_ready=1), or with all-ones if buffer empty.
REQ-019 SHALL drive miso_out = shift register MSB while ACTIVE and 0 while IDLE.
REQ-020 SHALL, on each sclk rise in ACTIVE, shift synchronized mosi into receive register LSB and increment a log2(WIDTH)+1-bit counter.
REQ-021 SHALL, on the WIDTH-th rise, copy assembled word to rx_data, pulse rx_valid on the following clk edge, and wrap counter to 0.
REQ-022 SHALL, on the first sclk fall after a word completes, reload shift register from buffer (or all-ones if empty) instead of shifting.
REQ-023 SHALL ignore sclk edges in IDLE.
REQ-024 SHALL, on cs_n rise with counter != 0, pulse frame_err for one clk, discard partial word, leave rx_data unchanged, no rx_valid.
REQ-025 SHALL ignore tx_load while tx_ready is 0; buffer contents SHALL NOT be overwritten.
REQ-026 SHALL, when tx_load and a buffer-to-shift transfer occur in the same cycle, transfer the old buffer state (all-ones if empty) and store tx_data for the next word.
REQ-027 SHALL pulse rx_valid and frame_err for exactly one clk each, never simultaneously.

Reset
REQ-028 SHALL on rst: state IDLE, counter 0, shift/receive registers 0, rx_data 0, rx_valid 0, frame_err 0, tx_ready 1, miso_out 0, synchronizer flops to idle levels (sclk 0, cs_n 1).
REQ-029 SHALL, after rst released mid-frame with cs_n low, stay IDLE until cs_n is seen high and then falls.

Verification
REQ-030 SHALL verify: tx_load 0x3C, cs_n low, master sends 0xA5 mode 0 -> rx_data 0xA5, one rx_valid pulse, MISO bits 0,0,1,1,1,1,0,0.
REQ-031 SHALL verify: two back-to-back words 0x01,0x80 in one cs_n frame, buffer empty -> rx_valid twice, rx_data 0x01 then 0x80, MISO 0xFF both words.
REQ-032 SHALL verify: cs_n raised after 5 bits -> frame_err one pulse, no rx_valid, rx_data holds prior value.
REQ-033 SHALL verify: tx_load 0x11 then tx_load 0x22 before frame -> tx_ready 0 after first, MISO returns 0x11.
REQ-034 SHALL verify: rst asserted after bit 3 with cs_n low -> outputs at reset values; following sclk pulses ignored until cs_n toggles high then low.
REQ-035 SHALL verify: sclk toggling with cs_n high -> no rx_valid, miso_out 0.
